// File: rtl/if_stage.sv
// Instruction fetch stage: IDLE/WAIT/HOLD fetch FSM feeding registered IF/ID outputs.
// Define ICACHE_EN to add a direct-mapped instruction cache of ICACHE_LINES words.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        branch_o
);

  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic        r_discard;
  logic [31:0] r_pc_o;
  logic [31:0] r_inst_o;
  logic        r_branch_o;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;

  logic        w_hit;
  logic [31:0] w_hit_inst;
  logic        w_accept;
  logic        w_emit;
  logic [31:0] w_emit_inst;
  logic        w_is_jal;
  logic [31:0] w_jimm;
  logic [31:0] w_next_pc;

  // A returned word is usable only if no redirect arrived with or before it
  assign w_accept = (r_state == WAIT) && mem_ready_i && !jump_i && !r_discard;
  assign w_emit   = !jump_i && !stall_i &&
                    (((r_state == IDLE) && w_hit) || w_accept || (r_state == HOLD));

  always_comb begin
    case (r_state)
      WAIT:    w_emit_inst = mem_inst_i;
      HOLD:    w_emit_inst = r_buf;
      default: w_emit_inst = w_hit_inst;
    endcase
  end

  assign w_is_jal  = (w_emit_inst[6:0] == OP_JAL);
  assign w_jimm    = {{12{w_emit_inst[31]}}, w_emit_inst[19:12], w_emit_inst[20],
                      w_emit_inst[30:21], 1'b0};
  assign w_next_pc = r_pc + (w_is_jal ? w_jimm : 32'd4);

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = (ICACHE_LINES > 1) ? $clog2(ICACHE_LINES) : 1;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [ICACHE_LINES-1:0] r_valid;
  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [31:0]             r_data [ICACHE_LINES];
  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_fill;

  assign w_idx      = r_pc[IDX_W+1:2];
  assign w_tag      = r_pc[31:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_inst = r_data[w_idx];
  assign w_fill     = rdy && w_accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every hit
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_inst_i;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_inst = 32'h0;

  // Line count only matters with the cache; nothing to build here
  if (ICACHE_LINES == 0) begin : g_no_lines
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_buf      <= 32'h0;
      r_discard  <= 1'b0;
      r_pc_o     <= 32'h0;
      r_inst_o   <= 32'h0;
      r_branch_o <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
    end else if (rdy) begin
      if (w_emit) begin
        r_pc_o     <= r_pc;
        r_inst_o   <= w_emit_inst;
        r_branch_o <= w_is_jal;
      end else if (jump_i || !stall_i) begin
        r_pc_o     <= 32'h0;
        r_inst_o   <= 32'h0;
        r_branch_o <= 1'b0;
      end

      if (jump_i) begin
        r_pc <= jump_addr_i;
        // An in-flight request cannot be withdrawn; remember to drop its data
        if ((r_state == WAIT) && !mem_ready_i) begin
          r_discard <= 1'b1;
        end else begin
          r_state   <= IDLE;
          r_discard <= 1'b0;
          r_mem_req <= 1'b0;
        end
      end else begin
        if (w_emit) begin
          r_pc    <= w_next_pc;
          r_state <= IDLE;
        end
        case (r_state)
          IDLE: begin
            if (!stall_i && !w_hit) begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_pc;
              r_state    <= WAIT;
            end
          end
          WAIT: begin
            if (mem_ready_i) begin
              r_mem_req <= 1'b0;
              r_discard <= 1'b0;
              if (r_discard) begin
                r_state <= IDLE;
              end else if (stall_i) begin
                r_buf   <= mem_inst_i;
                r_state <= HOLD;
              end
            end
          end
          HOLD: ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;
  assign pc_o       = r_pc_o;
  assign inst_o     = r_inst_o;
  assign branch_o   = r_branch_o;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed handshake scenarios plus a randomized
// run whose emitted instruction stream is compared with a program-order model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, rdy, stall_i, jump_i, mem_ready_i;
  logic [31:0] jump_addr_i, mem_inst_i;
  logic        mem_req_o, branch_o;
  logic [31:0] mem_addr_o, pc_o, inst_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [64];
  logic [31:0] step_of [64];
  logic        is_jal  [64];

  if_stage #(.RESET_PC(32'h0), .ICACHE_LINES(64)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_inst_i(mem_inst_i),
    .pc_o(pc_o), .inst_o(inst_o), .branch_o(branch_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_jal(input int off, input logic [4:0] rd);
    logic [20:0] im;
    im = 21'(off);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  task automatic serve(input int lat);
    for (int i = 0; i < 8 && mem_req_o !== 1'b1; i++) step();
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL serve_timeout: req=%b want 1", mem_req_o); end
    for (int i = 0; i < lat; i++) step();
    mem_ready_i = 1'b1; mem_inst_i = mem[mem_addr_o[7:2]];
    step();
    mem_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'h0;
    mem_ready_i = 1'b0; mem_inst_i = 32'h0;
    step(); step();
    total++; if ({mem_req_o, mem_addr_o, pc_o, inst_o, branch_o} !== '0) begin bad++;
      $display("FAIL reset: req=%b addr=%h pc=%h inst=%h br=%b want all 0", mem_req_o, mem_addr_o, pc_o, inst_o, branch_o); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || inst_o !== 32'h0) begin bad++;
        $display("FAIL first_wait c%0d: req=%b addr=%h inst=%h want 1/0/0", i, mem_req_o, mem_addr_o, inst_o); end
    end
    mem_ready_i = 1'b1; mem_inst_i = 32'h00500093;
    step();
    mem_ready_i = 1'b0;
    total++; if (pc_o !== 32'h0 || inst_o !== 32'h00500093 || branch_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++;
      $display("FAIL first_emit: pc=%h inst=%h br=%b req=%b want 0/00500093/0/0", pc_o, inst_o, branch_o, mem_req_o); end
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin bad++;
      $display("FAIL second_req: req=%b addr=%h want 1/4", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_jump_wait();
    jump_i = 1'b1; jump_addr_i = 32'h200;
    step();
    jump_i = 1'b0;
    total++; if (pc_o !== 32'h0 || inst_o !== 32'h0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin bad++;
      $display("FAIL jump_keep_req: pc=%h inst=%h req=%b addr=%h want 0/0/1/4", pc_o, inst_o, mem_req_o, mem_addr_o); end
    mem_ready_i = 1'b1; mem_inst_i = 32'h00A00113;
    step();
    mem_ready_i = 1'b0;
    total++; if (inst_o !== 32'h0 || mem_req_o !== 1'b0) begin bad++;
      $display("FAIL jump_discard: inst=%h req=%b want 0/0", inst_o, mem_req_o); end
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin bad++;
      $display("FAIL jump_refetch: req=%b addr=%h want 1/200", mem_req_o, mem_addr_o); end
    mem_ready_i = 1'b1; mem_inst_i = 32'h00C00213;
    step();
    mem_ready_i = 1'b0;
    total++; if (pc_o !== 32'h200 || inst_o !== 32'h00C00213) begin bad++;
      $display("FAIL jump_emit: pc=%h inst=%h want 200/00c00213", pc_o, inst_o); end
  endtask

  task automatic test_jal();
    jump_i = 1'b1; jump_addr_i = 32'h100;
    step();
    jump_i = 1'b0;
    total++; if (inst_o !== 32'h0 || mem_req_o !== 1'b0) begin bad++;
      $display("FAIL jal_redirect: inst=%h req=%b want 0/0", inst_o, mem_req_o); end
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin bad++;
      $display("FAIL jal_req: req=%b addr=%h want 1/100", mem_req_o, mem_addr_o); end
    mem_ready_i = 1'b1; mem_inst_i = 32'h010000EF;
    step();
    mem_ready_i = 1'b0;
    total++; if (pc_o !== 32'h100 || inst_o !== 32'h010000EF || branch_o !== 1'b1) begin bad++;
      $display("FAIL jal_emit: pc=%h inst=%h br=%b want 100/010000ef/1", pc_o, inst_o, branch_o); end
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h110) begin bad++;
      $display("FAIL jal_target: req=%b addr=%h want 1/110", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin mem_ready_i = 1'b1; mem_inst_i = 32'h00B00193; end
      step();
      mem_ready_i = 1'b0;
      total++; if (pc_o !== 32'h0 || inst_o !== 32'h0 || branch_o !== 1'b0 || (i >= 1 && mem_req_o !== 1'b0)) begin bad++;
        $display("FAIL stall_hold c%0d: pc=%h inst=%h br=%b req=%b", i, pc_o, inst_o, branch_o, mem_req_o); end
    end
    stall_i = 1'b0;
    step();
    total++; if (pc_o !== 32'h110 || inst_o !== 32'h00B00193 || branch_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++;
      $display("FAIL stall_release: pc=%h inst=%h br=%b req=%b want 110/00b00193/0/0", pc_o, inst_o, branch_o, mem_req_o); end
    stall_i = 1'b1;
    step();
    total++; if (pc_o !== 32'h110 || inst_o !== 32'h00B00193 || mem_req_o !== 1'b0) begin bad++;
      $display("FAIL stall_hold_emit: pc=%h inst=%h req=%b want 110/00b00193/0", pc_o, inst_o, mem_req_o); end
    stall_i = 1'b0;
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h114 || inst_o !== 32'h0) begin bad++;
      $display("FAIL stall_next_req: req=%b addr=%h inst=%h want 1/114/0", mem_req_o, mem_addr_o, inst_o); end
  endtask

  task automatic test_rdy_freeze();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready_i = (i % 2 == 0); mem_inst_i = 32'hDEADBEEF; stall_i = (i == 3);
      step();
      total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h114 || pc_o !== 32'h0 || inst_o !== 32'h0) begin bad++;
        $display("FAIL rdy_freeze c%0d: req=%b addr=%h pc=%h inst=%h want 1/114/0/0", i, mem_req_o, mem_addr_o, pc_o, inst_o); end
    end
    rdy = 1'b1; stall_i = 1'b0; mem_ready_i = 1'b1; mem_inst_i = 32'h00D00293;
    step();
    mem_ready_i = 1'b0;
    total++; if (pc_o !== 32'h114 || inst_o !== 32'h00D00293) begin bad++;
      $display("FAIL rdy_resume: pc=%h inst=%h want 114/00d00293", pc_o, inst_o); end
    rdy = 1'b0; jump_i = 1'b1; jump_addr_i = 32'h300;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (pc_o !== 32'h114 || inst_o !== 32'h00D00293 || mem_req_o !== 1'b0) begin bad++;
        $display("FAIL rdy_ignore_jump c%0d: pc=%h inst=%h req=%b", i, pc_o, inst_o, mem_req_o); end
    end
    rdy = 1'b1; jump_i = 1'b0;
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h118) begin bad++;
      $display("FAIL rdy_next_req: req=%b addr=%h want 1/118", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_reset_mid_wait();
    rst = 1'b0;
    step();
    total++; if ({mem_req_o, mem_addr_o, pc_o, inst_o} !== '0) begin bad++;
      $display("FAIL reset_wait: req=%b addr=%h pc=%h inst=%h want 0", mem_req_o, mem_addr_o, pc_o, inst_o); end
    rst = 1'b1;
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin bad++;
      $display("FAIL reset_refetch: req=%b addr=%h want 1/0", mem_req_o, mem_addr_o); end
    mem_ready_i = 1'b1; mem_inst_i = 32'h00500093;
    step();
    mem_ready_i = 1'b0;
    total++; if (pc_o !== 32'h0 || inst_o !== 32'h00500093) begin bad++;
      $display("FAIL reset_emit: pc=%h inst=%h want 0/00500093", pc_o, inst_o); end
  endtask

  task automatic test_wrap_and_coincident_jump();
    rst = 1'b0;
    step();
    rst = 1'b1; jump_i = 1'b1; jump_addr_i = 32'hFFFFFFFC;
    step();
    jump_i = 1'b0;
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFFFFFC) begin bad++;
      $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", mem_req_o, mem_addr_o); end
    mem_ready_i = 1'b1; mem_inst_i = 32'h00100093;
    step();
    mem_ready_i = 1'b0;
    total++; if (pc_o !== 32'hFFFFFFFC || inst_o !== 32'h00100093) begin bad++;
      $display("FAIL wrap_emit: pc=%h inst=%h want fffffffc/00100093", pc_o, inst_o); end
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin bad++;
      $display("FAIL wrap_next: req=%b addr=%h want 1/0", mem_req_o, mem_addr_o); end
    jump_i = 1'b1; jump_addr_i = 32'h40; mem_ready_i = 1'b1; mem_inst_i = 32'h00200113;
    step();
    jump_i = 1'b0; mem_ready_i = 1'b0;
    total++; if (inst_o !== 32'h0 || mem_req_o !== 1'b0) begin bad++;
      $display("FAIL coincide_discard: inst=%h req=%b want 0/0", inst_o, mem_req_o); end
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin bad++;
      $display("FAIL coincide_refetch: req=%b addr=%h want 1/40", mem_req_o, mem_addr_o); end
    mem_ready_i = 1'b1; mem_inst_i = 32'h00300193;
    step();
    mem_ready_i = 1'b0;
    total++; if (pc_o !== 32'h40 || inst_o !== 32'h00300193) begin bad++;
      $display("FAIL coincide_emit: pc=%h inst=%h want 40/00300193", pc_o, inst_o); end
  endtask

  task automatic test_loop_pass();
    mem[0] = 32'h00100093; mem[1] = 32'h00200113; mem[2] = 32'h00300193; mem[3] = enc_jal(-12, 5'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(1);
      total++; if (pc_o !== 32'(k * 4) || inst_o !== mem[k] || branch_o !== (k == 3)) begin bad++;
        $display("FAIL loop_pass1 k%0d: pc=%h inst=%h br=%b want %h/%h/%b", k, pc_o, inst_o, branch_o, 32'(k * 4), mem[k], k == 3); end
    end
`ifdef ICACHE_EN
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (mem_req_o !== 1'b0 || pc_o !== 32'(k * 4) || inst_o !== mem[k]) begin bad++;
        $display("FAIL loop_hit k%0d: req=%b pc=%h inst=%h want 0/%h/%h", k, mem_req_o, pc_o, inst_o, 32'(k * 4), mem[k]); end
    end
`else
    step();
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin bad++;
      $display("FAIL loop_refetch: req=%b addr=%h want 1/0", mem_req_o, mem_addr_o); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, p_pc, p_inst, p_addr, p_jaddr;
    logic        p_br, p_req, p_rdy, p_stall, p_jump, p_ready;
    int          emits = 0;
    for (int i = 0; i < 64; i++) begin
      if ($urandom % 5 == 0) begin
        int off;
        off = (int'($urandom % 16) - 8) * 4;
        mem[i] = enc_jal(off, 5'($urandom)); step_of[i] = 32'(off); is_jal[i] = 1'b1;
      end else begin
        mem[i] = {25'($urandom), 7'b0010011}; step_of[i] = 32'd4; is_jal[i] = 1'b0;
      end
    end
    rst = 1'b0; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0; mem_ready_i = 1'b0;
    step();
    rst = 1'b1;
    exp_pc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom % 8) != 0;
      stall_i = ($urandom % 4) == 0;
      jump_i = ($urandom % 40) == 0;
      jump_addr_i = ($urandom % 3 == 0) ? ($urandom & 32'hFFFFFFFC) : {24'h0, 6'($urandom), 2'b00};
      mem_ready_i = mem_req_o && ($urandom % 3 == 0);
      mem_inst_i = mem_ready_i ? mem[mem_addr_o[7:2]] : $urandom;
      p_pc = pc_o; p_inst = inst_o; p_br = branch_o; p_req = mem_req_o; p_addr = mem_addr_o;
      p_rdy = rdy; p_stall = stall_i; p_jump = jump_i; p_jaddr = jump_addr_i; p_ready = mem_ready_i;
      step();
      if (!p_rdy) begin
        total++; if ({pc_o, inst_o, branch_o, mem_req_o, mem_addr_o} !== {p_pc, p_inst, p_br, p_req, p_addr}) begin bad++;
          $display("FAIL rnd_freeze c%0d: pc=%h inst=%h req=%b addr=%h want %h/%h/%b/%h", c, pc_o, inst_o, mem_req_o, mem_addr_o, p_pc, p_inst, p_req, p_addr); end
      end else begin
        if (p_req && !p_ready) begin
          total++; if (mem_req_o !== 1'b1 || mem_addr_o !== p_addr) begin bad++;
            $display("FAIL rnd_req_stable c%0d: req=%b addr=%h want 1/%h", c, mem_req_o, mem_addr_o, p_addr); end
        end
        if (p_jump) begin
          total++; if (pc_o !== 32'h0 || inst_o !== 32'h0 || branch_o !== 1'b0) begin bad++;
            $display("FAIL rnd_jump_bubble c%0d: pc=%h inst=%h br=%b want 0", c, pc_o, inst_o, branch_o); end
          exp_pc = p_jaddr;
        end else if (p_stall) begin
          total++; if ({pc_o, inst_o, branch_o} !== {p_pc, p_inst, p_br}) begin bad++;
            $display("FAIL rnd_stall_hold c%0d: pc=%h inst=%h want %h/%h", c, pc_o, inst_o, p_pc, p_inst); end
        end else if (inst_o !== 32'h0) begin
          emits++;
          total++; if (pc_o !== exp_pc || inst_o !== mem[exp_pc[7:2]] || branch_o !== is_jal[exp_pc[7:2]]) begin bad++;
            $display("FAIL rnd_emit c%0d: pc=%h inst=%h br=%b want %h/%h/%b", c, pc_o, inst_o, branch_o, exp_pc, mem[exp_pc[7:2]], is_jal[exp_pc[7:2]]); end
          exp_pc = exp_pc + step_of[exp_pc[7:2]];
        end else begin
          total++; if (pc_o !== 32'h0 || branch_o !== 1'b0) begin bad++;
            $display("FAIL rnd_bubble c%0d: pc=%h br=%b want 0/0", c, pc_o, branch_o); end
        end
      end
    end
    total++; if (emits < 100) begin bad++;
      $display("FAIL rnd_progress: emitted=%0d want >=100", emits); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_jump_wait();
    test_jal();
    test_stall();
    test_rdy_freeze();
    test_reset_mid_wait();
    test_wrap_and_coincident_jump();
    test_loop_pass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
